// File: rtl/cirno9_sram_ctrl.sv
// +----------------------------------------------------------------------------+
// | cirno9_sram_ctrl : single-port 32-bit SRAM controller, fixed WAIT latency   |
// | Option macro     : CIRNO_SRAM_BUSERR_EN (out-of-range address -> o_err)     |
// | Revision         : 1.0 initial release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module cirno9_sram_ctrl #(
   parameter int WAIT = 1,
   parameter int AW   = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_sram_ren,
   input  logic [3:0]    i_sram_wen,
   input  logic [31:0]   i_adr,
   input  logic [31:0]   i_wdat,
   output logic          o_hs_ram4ls_rdy,
   output logic [31:0]   o_rdat,
   output logic          o_err,
   output logic          sram_ce,
   output logic [3:0]    sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_WT   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q, rd_d;
   logic          ce_q, ce_d;
   logic [3:0]    we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   rdat_q, rdat_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;

   logic w_req;
   logic w_oor;
   assign w_req = i_sram_ren | (|i_sram_wen);

`ifdef CIRNO_SRAM_BUSERR_EN
   logic w_unused_adr;
   assign w_oor        = |i_adr[31:AW+2];
   assign w_unused_adr = ^i_adr[1:0];
`else
   // Upper address bits alias onto the SRAM; they never reach any logic.
   logic w_unused_adr;
   assign w_oor        = 1'b0;
   assign w_unused_adr = ^{i_adr[31:AW+2], i_adr[1:0]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         ce_q    <= 1'b0;
         we_q    <= 4'd0;
         addr_q  <= '0;
         wdat_q  <= 32'd0;
         rdat_q  <= 32'd0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         ce_q    <= ce_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   // Strobes and handshake are computed one state ahead so every output is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      ce_d    = 1'b0;
      we_d    = 4'd0;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               rd_d   = (i_sram_wen == 4'd0);
               addr_d = i_adr[AW+1:2];
               wdat_d = i_wdat;
               if (w_oor) begin
                  state_d = S_RESP;
                  rdy_d   = 1'b1;
                  err_d   = 1'b1;
                  if (i_sram_wen == 4'd0) rdat_d = 32'd0;
               end else begin
                  state_d = S_ACC;
                  ce_d    = 1'b1;
                  we_d    = i_sram_wen;
               end
            end
         end
         S_ACC: begin
            state_d = S_WT;
            cnt_d   = 4'(WAIT - 1);
         end
         S_WT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               rdy_d   = 1'b1;
               if (rd_q) rdat_d = sram_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_hs_ram4ls_rdy = rdy_q;
   assign o_rdat          = rdat_q;
   assign sram_ce         = ce_q;
   assign sram_we         = we_q;
   assign sram_addr       = addr_q;
   assign sram_wdata      = wdat_q;

`ifdef CIRNO_SRAM_BUSERR_EN
   assign o_err = err_q;
`else
   logic w_unused_err;
   assign w_unused_err = err_q;
   assign o_err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cirno9_sram_ctrl.sv
// Scoreboard bench for cirno9_sram_ctrl: default instance (WAIT=1) on an SRAM model, plus a WAIT=4 instance.
`default_nettype none

module tb_cirno9_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_sram_ren = 1'b0;
   logic [3:0]  i_sram_wen = 4'd0;
   logic [31:0] i_adr = 32'd0;
   logic [31:0] i_wdat = 32'd0;
   logic        o_rdy;
   logic [31:0] o_rdat;
   logic        o_err;
   logic        sram_ce;
   logic [3:0]  sram_we;
   logic [13:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = 32'd0;

   logic        ren4 = 1'b0;
   logic [31:0] adr4 = 32'd0;
   logic        rdy4, err4, ce4;
   logic [31:0] rdat4, wdata4;
   logic [3:0]  we4;
   logic [13:0] addr4;
   logic [31:0] rdata4 = 32'h4444_0004;

   int cyc = 0;
   int n_vec = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] rdat;
      logic        err;
      int          t_due;
   } exp_t;
   exp_t q[$];
   exp_t q4[$];

   logic [31:0] mem [0:16383];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cirno9_sram_ctrl dut (
      .clk(clk), .rst(rst), .i_sram_ren(i_sram_ren), .i_sram_wen(i_sram_wen),
      .i_adr(i_adr), .i_wdat(i_wdat), .o_hs_ram4ls_rdy(o_rdy), .o_rdat(o_rdat),
      .o_err(o_err), .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   cirno9_sram_ctrl #(.WAIT(4), .AW(14)) dut4 (
      .clk(clk), .rst(rst), .i_sram_ren(ren4), .i_sram_wen(4'd0),
      .i_adr(adr4), .i_wdat(32'd0), .o_hs_ram4ls_rdy(rdy4), .o_rdat(rdat4),
      .o_err(err4), .sram_ce(ce4), .sram_we(we4), .sram_addr(addr4),
      .sram_wdata(wdata4), .sram_rdata(rdata4)
   );

   // Synchronous SRAM model: read data appears one cycle after the strobe and is held.
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we != 4'd0) begin
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && o_rdy) begin
         if (q.size() == 0) begin
            chk("spurious_rdy", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rdat", o_rdat, e.rdat);
            chk("err", {31'd0, o_err}, {31'd0, e.err});
            chk("rdy_cycle", cyc, e.t_due);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rdy4) begin
         if (q4.size() == 0) begin
            chk("spurious_rdy4", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            chk("rdat4", rdat4, e.rdat);
            chk("rdy4_cycle", cyc, e.t_due);
         end
      end
   end

   task automatic req(input logic ren, input logic [3:0] wen, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [31:0] exp_rdat, input logic exp_err,
                      input int lat, input int exp_ce, input logic [13:0] exp_addr);
      int  t0;
      int  nce;
      bit  got;
      @(posedge clk); #1;
      i_sram_ren = ren;
      i_sram_wen = wen;
      i_adr      = adr;
      i_wdat     = wdat;
      t0         = cyc;
      q.push_back('{exp_rdat, exp_err, t0 + lat});
      nce = 0;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (sram_ce) begin
            nce++;
            chk("ce_cycle", cyc, t0 + 1);
            chk("sram_addr", {18'd0, sram_addr}, {18'd0, exp_addr});
            chk("sram_we", {28'd0, sram_we}, {28'd0, wen});
         end
         if (o_rdy) got = 1;
      end
      if (!got) chk("rdy_timeout", 32'd0, 32'd1);
      chk("ce_count", nce, exp_ce);
      i_sram_ren = 1'b0;
      i_sram_wen = 4'd0;
   endtask

   initial begin
      int t0;
      int nce;
      int ce_at;
      bit got;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int nce;
      int ce_at;
      bit got;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdat", o_rdat, 32'd0);
      chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      chk("rst_ce", {31'd0, sram_ce}, 32'd0);
      chk("rst_we", {28'd0, sram_we}, 32'd0);
      chk("rst_addr", {18'd0, sram_addr}, 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      req(1'b0, 4'hF,    32'h10, 32'hA5A5_1234, 32'h0000_0000, 1'b0, 3, 1, 14'd4);
      req(1'b1, 4'h0,    32'h10, 32'h0,         32'hA5A5_1234, 1'b0, 3, 1, 14'd4);
      req(1'b0, 4'b0010, 32'h10, 32'h0000_BB00, 32'hA5A5_1234, 1'b0, 3, 1, 14'd4);
      req(1'b1, 4'h0,    32'h10, 32'h0,         32'hA5A5_BB34, 1'b0, 3, 1, 14'd4);
      req(1'b1, 4'hF,    32'h20, 32'h1111_2222, 32'hA5A5_BB34, 1'b0, 3, 1, 14'd8);
      req(1'b1, 4'h0,    32'h20, 32'h0,         32'h1111_2222, 1'b0, 3, 1, 14'd8);

      // Abort a read in its WT cycle; the held o_rdat must clear at once.
      @(posedge clk); #1;
      i_sram_ren = 1'b1;
      i_adr      = 32'h10;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_ce", {31'd0, sram_ce}, 32'd0);
      chk("abort_rdy", {31'd0, o_rdy}, 32'd0);
      chk("abort_rdat", o_rdat, 32'd0);
      i_sram_ren = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      repeat (6) @(posedge clk);

      req(1'b1, 4'h0,    32'h10, 32'h0,         32'hA5A5_BB34, 1'b0, 3, 1, 14'd4);
      req(1'b0, 4'hF,    32'h00, 32'hDEAD_BEEF, 32'hA5A5_BB34, 1'b0, 3, 1, 14'd0);
`ifdef CIRNO_SRAM_BUSERR_EN
      req(1'b1, 4'h0,    32'h0001_0000, 32'h0,  32'h0000_0000, 1'b1, 1, 0, 14'd0);
`else
      req(1'b1, 4'h0,    32'h0001_0000, 32'h0,  32'hDEAD_BEEF, 1'b0, 3, 1, 14'd0);
`endif

      // WAIT=4 instance: strobe in N+1, single rdy in N+6.
      @(posedge clk); #1;
      ren4 = 1'b1;
      adr4 = 32'h8;
      t0   = cyc;
      q4.push_back('{32'h4444_0004, 1'b0, t0 + 6});
      nce   = 0;
      ce_at = -1;
      got   = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (ce4) begin
            nce++;
            ce_at = cyc;
         end
         if (rdy4) got = 1;
      end
      ren4 = 1'b0;
      if (!got) chk("rdy4_timeout", 32'd0, 32'd1);
      chk("ce4_count", nce, 32'd1);
      chk("ce4_cycle", ce_at, t0 + 1);
      repeat (8) @(posedge clk);

      chk("sb_empty", q.size() + q4.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cirno9_sram_ctrl.md
CIRNO9_SRAM_CTRL -- requirements
Module: cirno9_sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT, default 1, meaning SRAM wait cycles after the access strobe; legal range 1..15.
REQ-002 SHALL have parameter AW, default 14, meaning SRAM word-address width (depth 2^AW words of 32 bits).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_sram_ren  input  1  core read request.
REQ-006 SHALL have port i_sram_wen  input  4  core byte write enables; a nonzero value is a write request.
REQ-007 SHALL have port i_adr  input  32  core byte address.
REQ-008 SHALL have port i_wdat  input  32  core write data.
REQ-009 SHALL have port o_hs_ram4ls_rdy  output  1  one-cycle completion pulse to the core.
REQ-010 SHALL have port o_rdat  output  32  read data, valid while o_hs_ram4ls_rdy=1 and held until the next read completes.
REQ-011 SHALL have port o_err  output  1  access error flag, qualified by o_hs_ram4ls_rdy.
REQ-012 SHALL have port sram_ce  output  1  SRAM chip enable strobe.
REQ-013 SHALL have port sram_we  output  4  SRAM byte write enables.
REQ-014 SHALL have port sram_addr  output  AW  SRAM word address.
REQ-015 SHALL have port sram_wdata  output  32  SRAM write data.
REQ-016 SHALL have port sram_rdata  input  32  SRAM read data, valid 1 cycle after a read strobe and held until the next strobe.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, WT and RESP.
REQ-018 In IDLE, a request (i_sram_ren=1 or i_sram_wen!=0) SHALL register i_adr, i_wdat and i_sram_wen and move to ACC; otherwise stay in IDLE.
REQ-019 ACC SHALL last exactly 1 cycle: sram_ce=1, sram_addr=latched adr[AW+1:2], sram_we=latched wen, sram_wdata=latched wdat; then move to WT.
REQ-020 WT SHALL last exactly WAIT cycles, counted by a 4-bit down-counter, with sram_ce=0 and sram_we=0; then move to RESP.
REQ-021 On a read, the edge leaving WT SHALL capture sram_rdata into o_rdat.
REQ-022 RESP SHALL last 1 cycle with o_hs_ram4ls_rdy=1, then return to IDLE.
REQ-023 Latency: a request first seen in cycle N SHALL produce rdy in cycle N+2+WAIT (N+3 at default).
REQ-024 If a request has both read and nonzero wen, the write SHALL take precedence and o_rdat SHALL be unchanged.
REQ-025 A write SHALL leave o_rdat unchanged.
REQ-026 Request inputs SHALL be ignored outside IDLE; the core holds them until rdy.
REQ-027 The cycle after RESP is IDLE, so a new request presented then SHALL be accepted: back-to-back spacing is 3+WAIT cycles.
REQ-028 sram_ce and sram_we SHALL be registered outputs, glitch-free.

Reset
REQ-029 While rst=1: state=IDLE, counter=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, o_rdat=0, o_hs_ram4ls_rdy=0, o_err=0.
REQ-030 Reset asserted mid-access SHALL abort it immediately; no rdy pulse is issued for the aborted request after release.

Configuration
REQ-031 Macro CIRNO_SRAM_BUSERR_EN SHALL control out-of-range detection.
REQ-032 With the macro defined: a request with i_adr[31:AW+2]!=0 SHALL skip ACC and WT (no sram_ce) and go IDLE->RESP. In that RESP, o_err=1; for a read, o_rdat=0.
REQ-033 With the macro defined: in-range accesses SHALL give o_err=0.
REQ-034 Without the macro: upper address bits SHALL be ignored (aliasing), o_err SHALL be tied 0, and the port SHALL remain present.

Verification
REQ-035 Write then read: write adr=0x10, wen=4'hF, wdat=0xA5A5_1234 -> sram_ce, sram_we=4'hF, sram_addr=4 in cycle N+1, rdy at N+3; then read adr=0x10 -> o_rdat=0xA5A5_1234 with rdy at N+3.
REQ-036 Byte write: wen=4'b0010, wdat=0x0000_BB00 to adr=0x10, then read -> 0xA5A5_BB34.
REQ-037 WAIT=4: read request in cycle N -> single rdy pulse in cycle N+6; sram_ce high only in N+1.
REQ-038 Reset mid-access: rst asserted in the WT cycle -> sram_ce=0, rdy=0 and o_rdat=0 immediately; no rdy after release; the next read completes normally.
REQ-039 Simultaneous ren=1 and wen=4'hF -> write performed, o_rdat keeps its prior value.
REQ-040 With CIRNO_SRAM_BUSERR_EN, AW=14: read adr=0x0001_0000 -> no sram_ce, rdy with o_err=1 and o_rdat=0 in cycle N+1. Without the macro: same stimulus accesses sram_addr=0 with o_err=0.
